// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift_seq_ctrl serializer.
// SHIFT_SEQ_PARITY_EN adds the PARITY state to the state enum.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef SHIFT_SEQ_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_GAP    = 2'd3
  } shift_seq_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter shared by the bit-shift and inter-frame gap phases.
module shift_seq_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// MSB-first serializer controller with optional even-parity bit and idle gap.
// Define SHIFT_SEQ_PARITY_EN to append a parity bit to every frame.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ser_out,
  output logic             shift_en,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = (max2(WIDTH, GAP + 1) > 1) ? $clog2(max2(WIDTH, GAP + 1)) : 1;
  localparam logic [CNT_W-1:0] LD_BITS = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

  shift_seq_state_t state_q, state_d;
  logic [WIDTH-1:0] word_q;
  logic             word_load;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val, cnt;
  logic             bit_sel;
  logic             handshake;

  assign handshake = s_valid && s_ready;

  shift_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_ld_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (word_load) begin
      word_q <= s_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_load  = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_ld_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d    = ST_SHIFT;
          word_load  = 1'b1;
          cnt_load   = 1'b1;
          cnt_ld_val = LD_BITS;
        end
      end
      ST_SHIFT: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
`ifdef SHIFT_SEQ_PARITY_EN
          state_d = ST_PARITY;
`else
          if (GAP > 0) begin
            state_d    = ST_GAP;
            cnt_load   = 1'b1;
            cnt_ld_val = LD_GAP;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end
      end
`ifdef SHIFT_SEQ_PARITY_EN
      ST_PARITY: begin
        if (GAP > 0) begin
          state_d    = ST_GAP;
          cnt_load   = 1'b1;
          cnt_ld_val = LD_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      ST_GAP: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The counter runs WIDTH-1 down to 0, so it directly indexes the MSB-first bit.
  always_comb begin
    bit_sel = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CNT_W'(i)) bit_sel = word_q[i];
    end
  end

  always_comb begin
    ser_out    = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != ST_IDLE);
    s_ready    = (state_q == ST_IDLE) && !rst;
    case (state_q)
      ST_SHIFT: begin
        ser_out  = bit_sel;
        shift_en = 1'b1;
`ifndef SHIFT_SEQ_PARITY_EN
        frame_done = cnt_zero;
`endif
      end
`ifdef SHIFT_SEQ_PARITY_EN
      ST_PARITY: begin
        ser_out    = ^word_q;
        shift_en   = 1'b1;
        frame_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: GAP=2 instance plus a GAP=0 instance.
// Expectations follow SHIFT_SEQ_PARITY_EN when the bench is built with it.
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready, ser_out, shift_en, frame_done, busy;

  logic [7:0] d1 = 8'h00;
  logic       v1 = 1'b0;
  logic       r1, so1, se1, fd1, b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(8), .GAP(2)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ser_out(ser_out), .shift_en(shift_en), .frame_done(frame_done), .busy(busy)
  );

  shift_seq_ctrl #(.WIDTH(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .s_data(d1), .s_valid(v1), .s_ready(r1),
    .ser_out(so1), .shift_en(se1), .frame_done(fd1), .busy(b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge showing the first bit; returns at the negedge after the gap.
  task automatic expect_frame(input string tag, input logic [7:0] w, input logic par,
                              input bit scramble);
    for (int i = 0; i < 8 + PAR; i++) begin
      chk({tag, "_ser"}, ser_out, (i < 8) ? w[7-i] : par);
      chk({tag, "_sen"}, shift_en, 1'b1);
      chk({tag, "_fd"}, frame_done, (i == 7 + PAR) ? 1'b1 : 1'b0);
      chk({tag, "_rdy"}, s_ready, 1'b0);
      chk({tag, "_busy"}, busy, 1'b1);
      if (scramble) begin
        s_valid = i[0];
        s_data  = ~w ^ 8'(i);
      end
      @(negedge clk);
    end
    if (scramble) s_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_gap_ser"}, ser_out, 1'b0);
      chk({tag, "_gap_sen"}, shift_en, 1'b0);
      chk({tag, "_gap_fd"}, frame_done, 1'b0);
      chk({tag, "_gap_rdy"}, s_ready, 1'b0);
      chk({tag, "_gap_busy"}, busy, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic start(input logic [7:0] w);
    s_data  = w;
    s_valid = 1'b1;
    chk("start_rdy", s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;

    // reset state
    @(negedge clk);
    chk("rst_rdy", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ser", ser_out, 1'b0);
    chk("rst_sen", shift_en, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_rdy0", r1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", s_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // basic frame
    start(8'hA5);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    chk("a5_after_rdy", s_ready, 1'b1);

    // odd-parity-count word
    start(8'h07);
    expect_frame("x07", 8'h07, 1'b1, 1'b0);

    // back-to-back with s_valid held high
    s_data  = 8'hFF;
    s_valid = 1'b1;
    @(negedge clk);
    s_data = 8'h00;
    expect_frame("ff", 8'hFF, 1'b0, 1'b0);
    chk("b2b_idle_rdy", s_ready, 1'b1);
    chk("b2b_idle_sen", shift_en, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    expect_frame("x00", 8'h00, 1'b0, 1'b0);

    // asynchronous abort after bit 3
    start(8'hC3);
    for (int i = 0; i < 4; i++) begin
      chk("c3_ser", ser_out, c3[7-i]);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_ser", ser_out, 1'b0);
    chk("abort_sen", shift_en, 1'b0);
    chk("abort_fd", frame_done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rdy", s_ready, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_after_rdy", s_ready, 1'b1);
    chk("abort_after_fd", frame_done, 1'b0);
    start(8'h3C);
    expect_frame("x3c", 8'h3C, 1'b0, 1'b0);

    // input activity during SHIFT is ignored
    start(8'h96);
    expect_frame("x96", 8'h96, 1'b0, 1'b1);
    chk("scr_rdy", s_ready, 1'b1);
    @(negedge clk);
    chk("scr_noframe_busy", busy, 1'b0);
    chk("scr_noframe_sen", shift_en, 1'b0);

    // GAP=0 instance returns straight to IDLE
    d1 = 8'h81;
    v1 = 1'b1;
    chk("g0_start_rdy", r1, 1'b1);
    @(negedge clk);
    v1 = 1'b0;
    for (int i = 0; i < 8 + PAR; i++) begin
      chk("g0_ser", so1, (i == 0 || i == 7) ? 1'b1 : 1'b0);
      chk("g0_sen", se1, 1'b1);
      chk("g0_fd", fd1, (i == 7 + PAR) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    chk("g0_rdy_next", r1, 1'b1);
    chk("g0_busy_next", b1, 1'b0);
    chk("g0_sen_next", se1, 1'b0);
    d1 = 8'h40;
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    chk("g0_f2_bit0", so1, 1'b0);
    @(negedge clk);
    chk("g0_f2_bit1", so1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word bits per frame; legal range 2..32.
REQ-002 SHALL have parameter GAP, default 2: idle cycles after each frame; legal range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_data  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port s_valid  input  1  s_data is valid.
REQ-007 SHALL have port s_ready  output  1  controller accepts a word this cycle.
REQ-008 SHALL have port ser_out  output  1  serial bit stream to the downstream shift register's in.
REQ-009 SHALL have port shift_en  output  1  high while ser_out carries a frame bit.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse on the final bit of a frame.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT, PARITY (present only with the macro from REQ-024) and GAP.
REQ-013 SHALL drive s_ready = (state==IDLE) && !rst; handshake = s_valid && s_ready at a rising edge.
REQ-014 SHALL capture s_data into an internal word register only on the handshake edge; s_data changes at other times have no effect.
REQ-015 SHALL enter SHIFT on the handshake edge, with first bit on ser_out the cycle after handshake (latency 1).
REQ-016 SHALL shift MSB first: in SHIFT cycle n (n=0..WIDTH-1), ser_out = word[WIDTH-1-n] and shift_en = 1.
REQ-017 SHALL, after the SHIFT cycle with n = WIDTH-1, go to PARITY if compiled in, else to GAP when GAP>0, else to IDLE.
REQ-018 SHALL hold GAP for exactly GAP cycles with ser_out=0 and shift_en=0, then go to IDLE.
REQ-019 SHALL assert frame_done only in the cycle carrying the last frame bit (bit WIDTH-1, or the parity bit when compiled in).
REQ-020 SHALL ignore s_valid outside IDLE; no word is queued. Minimum frame period is 1 + WIDTH (+1 parity) + GAP cycles.
REQ-021 SHALL drive ser_out=0 and shift_en=0 in IDLE.

Reset
REQ-022 SHALL, while rst is high, asynchronously force state=IDLE, bit counter=0, word=0, ser_out=0, shift_en=0, frame_done=0 and busy=0; s_ready=0.
REQ-023 SHALL treat rst asserted mid-frame as an abort: no frame_done, captured word discarded, s_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-024 SHALL, with macro SHIFT_SEQ_PARITY_EN defined, append one PARITY cycle after bit WIDTH-1 with ser_out = even parity (XOR of all word bits) and shift_en=1; without the macro, the PARITY state and its logic SHALL NOT exist and frames are WIDTH bits.

Structure
REQ-025 SHALL take the FSM state enum typedef (shift_seq_state_t) and the default WIDTH/GAP constants from package shift_seq_pkg.
REQ-026 SHALL place the bit/gap counter in sub-module shift_seq_counter (load, decrement, zero flag; width $clog2 of max(WIDTH,GAP+1)).

Verification
REQ-027 SHALL cover the following case: reset, then handshake 8'hA5 with GAP=2 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles with shift_en=1, frame_done on the 8th, s_ready low for 10 cycles.
REQ-028 SHALL cover the following case: s_valid held high with 8'hFF then 8'h00 -> exactly 2 shift_en-low GAP cycles plus 1 IDLE handshake cycle between the frames.
REQ-029 SHALL cover the following case: rst pulsed asynchronously after bit 3 of 8'hC3 -> all outputs 0 immediately, no frame_done, next frame 8'h3C serialized correctly.
REQ-030 SHALL cover the following case: s_data changed and s_valid toggled during SHIFT -> serialized bits unchanged, no extra frame started.
REQ-031 SHALL cover the following case: with SHIFT_SEQ_PARITY_EN, 8'hA5 -> 9th bit 0; 8'h07 -> 9th bit 1; frame_done on the 9th bit.
REQ-032 SHALL cover the following case: GAP=0 -> after the last bit, state returns to IDLE directly and s_ready=1 the next cycle.
